// File: rtl/audio_pkg.sv
// Shared constants and types for the audio capture/playback SRAM path.
// Lane 3 holds the earliest sample of a word; the playback decoder relies on the same order.
package audio_pkg;

  localparam int unsigned SAMPLE_W       = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;

  localparam logic [LANE_W-1:0] FIRST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } packer_state_t;

  function automatic logic [4:0] lane_lsb(input logic [LANE_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

  function automatic logic [WORD_W-1:0] pad_word(input logic [SAMPLE_W-1:0] pad);
    return {BYTES_PER_WORD{pad}};
  endfunction

endpackage

// File: rtl/audio_sram_packer.sv
// Packs 8-bit capture samples four per 32-bit word and writes them to sequential SRAM words.
// Capture ends on stop (partial word flushed with pad bytes) or after the last SRAM word.
module audio_sram_packer
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DEPTH    = 32768,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [ADDR_W-1:0]   sram_addrb,
  output logic [WORD_W-1:0]   sram_dinb,
  output logic                sram_enb,
  output logic                sram_web,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  packer_state_t       state;
  logic [LANE_W-1:0]   idx;
  logic [WORD_W-1:0]   word;
  logic [ADDR_W-1:0]   addr;
  logic                flush_pending;
  logic                enb_q;

  logic accept_c;
  logic held_c;
  logic last_addr_c;

  assign accept_c    = sample_valid && sample_ready;
  assign held_c      = accept_c || (idx != FIRST_LANE);
  assign last_addr_c = (addr == LAST_ADDR);

  // A reset arriving during the write cycle suppresses that cycle's strobe.
  assign sram_enb   = enb_q && !rst;
  assign sram_web   = enb_q && !rst;
  assign sram_addrb = addr;
  assign sram_dinb  = word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= FIRST_LANE;
      word          <= '0;
      addr          <= '0;
      flush_pending <= 1'b0;
      enb_q         <= 1'b0;
      sample_ready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      word_count    <= '0;
    end else begin
      enb_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= FILL;
            addr          <= '0;
            word_count    <= '0;
            word          <= pad_word(PAD_BYTE);
            idx           <= FIRST_LANE;
            flush_pending <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b1;
            sample_ready  <= 1'b1;
          end
        end

        FILL: begin
          if (accept_c) begin
            word[lane_lsb(idx) +: SAMPLE_W] <= sample_in;
            if (idx != '0) begin
              idx <= idx - LANE_W'(1);
            end
          end
          // The same-cycle byte is kept before deciding whether a flush write is needed.
          if (stop) begin
            if (held_c) begin
              flush_pending <= 1'b1;
              state         <= WRITE;
              sample_ready  <= 1'b0;
              enb_q         <= 1'b1;
            end else begin
              state        <= DONE;
              sample_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end
          end else if (accept_c && (idx == '0)) begin
            state        <= WRITE;
            sample_ready <= 1'b0;
            enb_q        <= 1'b1;
          end
        end

        WRITE: begin
          word_count <= word_count + CNT_W'(1);
          if (stop || flush_pending || last_addr_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= FILL;
            addr         <= addr + ADDR_W'(1);
            idx          <= FIRST_LANE;
            word         <= pad_word(PAD_BYTE);
            sample_ready <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          sample_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/audio_sram_packer.md
Name: audio_sram_packer

Overview:
Capture-side counterpart of the audio playback path. Accepts 8-bit audio samples over a valid/ready handshake and packs four per 32-bit word, earliest sample in bits [31:24]. Writes each completed word to the audio SRAM at sequential word addresses starting at 0. This byte order and addressing match what the playback decoder reads back.

Parameters:
ADDR_W, 15, SRAM word-address width.
DEPTH, 32768, number of words that may be written before capture ends; must be at most 2**ADDR_W.
PAD_BYTE, 8'h00, fill value for unused byte lanes of a flushed partial word.

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
start  in  1  one-cycle pulse; begins a capture at address 0.
stop  in  1  one-cycle pulse; flushes any partial word and ends the capture.
sample_in  in  8  sample byte.
sample_valid  in  1  sample_in is valid.
sample_ready  out  1  packer accepts a byte this cycle.
sram_addrb  out  ADDR_W  SRAM word address.
sram_dinb  out  32  SRAM write data.
sram_enb  out  1  SRAM port enable; asserted only on a write cycle.
sram_web  out  1  SRAM write enable; equals sram_enb.
busy  out  1  high in FILL and WRITE.
done  out  1  level; high in DONE until the next start.
word_count  out  ADDR_W+1  words written in the current or last capture.

Behaviour:
- Reset: sample_ready=0, sram_addrb=0, sram_dinb=0, sram_enb=0, sram_web=0, busy=0, done=0, word_count=0.
  - Internal registers reset as follows: byte index idx=3, word register=0, flush_pending=0, state=IDLE.
  - Reset mid-write wins: no write strobe is issued in the reset cycle.
- Byte accept: a byte transfers when sample_valid and sample_ready are both high. The packer writes it to word[idx*8 +: 8].
- State IDLE: sample_ready=0.
  - On start: addr=0, word_count=0, word={4{PAD_BYTE}}, idx=3, done=0, go to FILL.
- State FILL: sample_ready=1.
  - On accept with idx==0: go to WRITE.
  - On accept with idx!=0: idx decrements.
  - stop in FILL, with or without a same-cycle accept (the byte is taken first):
    - if any byte is held after this cycle, set flush_pending and go to WRITE;
    - if no byte is held, go straight to DONE with no write.
- State WRITE: exactly one cycle. sram_enb=sram_web=1, sram_addrb=addr, sram_dinb=word, sample_ready=0.
  - In the next cycle word_count increments.
  - Ends the capture (go to DONE) if flush_pending is set or addr==DEPTH-1.
  - Otherwise: addr increments, idx=3, word={4{PAD_BYTE}}, go to FILL.
  - A stop arriving during WRITE sets flush_pending; the capture ends after this write.
- State DONE: done=1, busy=0, sample_ready=0.
  - start begins a new capture as in IDLE.
- start is ignored while busy. stop is ignored in IDLE and DONE.
- Latency: fourth byte accepted in cycle N, write strobe in cycle N+1, sample_ready high again in N+2. Peak throughput is 4 bytes per 5 cycles.
- Outside WRITE: sram_addrb holds addr and sram_dinb shows the word register. The SRAM does not act on them because enb is low.
- Full memory: after the write to DEPTH-1 the block enters DONE; addr never wraps.
- word_count saturates at DEPTH by construction.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W=8, WORD_W=32, BYTES_PER_WORD=4;
  - the packer state enum {IDLE, FILL, WRITE, DONE};
  - the byte-lane convention (earliest sample in lane 3).
- The playback decoder imports the same lane constant.
- No sub-module; the FSM, byte index counter and address counter live in one module.

Test Plan:
- start, then bytes 11,22,33,44 back-to-back -> one cycle of enb=web=1 with addrb=0, dinb=32'h11223344; word_count=1; ready low for exactly one cycle.
- start, 8 bytes 01..08 with valid held high -> writes 32'h01020304 @0 and 32'h05060708 @1; the 5th byte is accepted two cycles after the 4th.
- start, bytes AA,BB, then stop -> single write 32'hAABB0000 @0; done=1 the following cycle; word_count=1.
- start, 4 bytes, stop in the WRITE cycle -> one write only, then done=1. Separately: start then immediate stop -> no write, done=1, word_count=0.
- DEPTH=4, stream 20 bytes -> writes @0..3, done after the 4th write, sample_ready stays 0; then start -> new capture writes @0.
- rst asserted in the cycle after the 4th byte is accepted -> no web pulse; all outputs at reset values; the next start behaves as a fresh capture.
